// File: rtl/uart_fifo_if.sv
// UART-side bundle: receiver byte handoff and transmitter start.
// master = FIFO front end, slave = raw UART pair.
interface uart_fifo_if;
  logic       uart_valid;
  logic [7:0] uart_rxd;
  logic       uart_rd;
  logic       uart_busy;
  logic       uart_wr;
  logic [7:0] uart_txd;

  modport master (
    input  uart_valid,
    input  uart_rxd,
    input  uart_busy,
    output uart_rd,
    output uart_wr,
    output uart_txd
  );

  modport slave (
    output uart_valid,
    output uart_rxd,
    output uart_busy,
    input  uart_rd,
    input  uart_wr,
    input  uart_txd
  );
endinterface

// File: rtl/uart_fifo.sv
// Buffered CPU <-> UART front end: one RX and one TX
// synchronous FIFO, show-ahead heads, sticky drop flags.
module uart_fifo_buf #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          resetq,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          avail
);
  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_C = DEPTH[AW:0];

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count_nxt;

  always_comb begin
    count_nxt = count;
    unique case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // full/avail are registered from the next count
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
      avail <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == FULL_C);
      avail <= (count_nxt != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  assign dout = mem[rptr];
endmodule

module uart_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  resetq,
  input  logic                  rd,
  input  logic                  wr,
  input  logic [7:0]            tx_data,
  output logic [7:0]            rx_data,
  output logic                  rx_avail,
  output logic                  tx_full,
  output logic [DEPTH_LOG2:0]   rx_count,
  output logic [DEPTH_LOG2:0]   tx_count,
  output logic                  rx_overrun,
  output logic                  tx_overflow,
  input  logic                  clr_err,
  uart_fifo_if.master           uart
);
  logic rx_full;
  logic rx_pop;
  logic rx_push;
  logic rx_drop;
  logic tx_avail;
  logic tx_pop;
  logic tx_push;
  logic tx_drop;

  // a full FIFO still accepts when it pops the same cycle
  assign rx_pop  = rd & rx_avail;
  assign rx_push = uart.uart_valid
                 & (~rx_full | rx_pop);
  assign rx_drop = uart.uart_valid
                 & rx_full & ~rx_pop;

  assign tx_pop  = tx_avail & ~uart.uart_busy;
  assign tx_push = wr & (~tx_full | tx_pop);
  assign tx_drop = wr & tx_full & ~tx_pop;

  assign uart.uart_rd = uart.uart_valid;
  assign uart.uart_wr = tx_pop;

  uart_fifo_buf #(.AW(DEPTH_LOG2)) rx_buf (
    .clk    (clk),
    .resetq (resetq),
    .push   (rx_push),
    .pop    (rx_pop),
    .din    (uart.uart_rxd),
    .dout   (rx_data),
    .count  (rx_count),
    .full   (rx_full),
    .avail  (rx_avail)
  );

  uart_fifo_buf #(.AW(DEPTH_LOG2)) tx_buf (
    .clk    (clk),
    .resetq (resetq),
    .push   (tx_push),
    .pop    (tx_pop),
    .din    (tx_data),
    .dout   (uart.uart_txd),
    .count  (tx_count),
    .full   (tx_full),
    .avail  (tx_avail)
  );

  // set wins over a same-cycle clear
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_overrun  <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      if (rx_drop)      rx_overrun <= 1'b1;
      else if (clr_err) rx_overrun <= 1'b0;
      if (tx_drop)      tx_overflow <= 1'b1;
      else if (clr_err) tx_overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_fifo.sv
// Randomized self-checking bench for uart_fifo against
// a queue-based model of the two FIFOs and sticky flags.
module tb_uart_fifo;
  localparam int AW = 4;
  localparam int D  = 1 << AW;
  typedef logic [AW:0] cnt_t;

  logic       clk = 1'b0;
  logic       resetq = 1'b1;
  logic       rd = 1'b0;
  logic       wr = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_avail;
  logic       tx_full;
  cnt_t       rx_count;
  cnt_t       tx_count;
  logic       rx_overrun;
  logic       tx_overflow;

  uart_fifo_if u();

  uart_fifo #(.DEPTH_LOG2(AW)) dut (
    .clk         (clk),
    .resetq      (resetq),
    .rd          (rd),
    .wr          (wr),
    .tx_data     (tx_data),
    .rx_data     (rx_data),
    .rx_avail    (rx_avail),
    .tx_full     (tx_full),
    .rx_count    (rx_count),
    .tx_count    (tx_count),
    .rx_overrun  (rx_overrun),
    .tx_overflow (tx_overflow),
    .clr_err     (clr_err),
    .uart        (u)
  );

  always #5 clk = ~clk;

  int cmp = 0;
  int bad = 0;
  byte unsigned rxq[$];
  byte unsigned txq[$];
  bit m_ovr = 1'b0;
  bit m_ovf = 1'b0;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  // model of one clock edge using the inputs now applied
  task automatic model_step();
    bit rpop, racc, rdrop, tpop, tacc, tdrop;
    rpop  = rd && rxq.size() > 0;
    racc  = u.uart_valid && (rxq.size() < D || rpop);
    rdrop = u.uart_valid && !racc;
    tpop  = txq.size() > 0 && !u.uart_busy;
    tacc  = wr && (txq.size() < D || tpop);
    tdrop = wr && !tacc;
    if (rpop) void'(rxq.pop_front());
    if (racc) rxq.push_back(u.uart_rxd);
    if (tpop) void'(txq.pop_front());
    if (tacc) txq.push_back(tx_data);
    m_ovr = rdrop ? 1'b1 : (clr_err ? 1'b0 : m_ovr);
    m_ovf = tdrop ? 1'b1 : (clr_err ? 1'b0 : m_ovf);
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd = 0; wr = 0; clr_err = 0; tx_data = 0;
    u.uart_valid = 0; u.uart_rxd = 0; u.uart_busy = 0;
  endtask

  task automatic model_reset();
    rxq.delete(); txq.delete();
    m_ovr = 0; m_ovf = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    #2 resetq = 0;
    u.uart_valid = 1;
    #1;
    if (u.uart_rd !== 1'b1) begin bad++;
      $display("FAIL reset_uart_rd got %b want 1", u.uart_rd); end
    cmp++;
    if (u.uart_wr !== 1'b0) begin bad++;
      $display("FAIL reset_uart_wr got %b want 0", u.uart_wr); end
    cmp++;
    u.uart_valid = 0;
    repeat (2) @(posedge clk);
    #1 resetq = 1;
    model_reset();
    repeat (10) cyc();
    if ({rx_avail, tx_full, rx_overrun, tx_overflow, u.uart_wr} !== 5'b0) begin
      bad++;
      $display("FAIL reset_status got %b want 00000",
        {rx_avail, tx_full, rx_overrun, tx_overflow, u.uart_wr});
    end
    cmp++;
    if (rx_count !== 0 || tx_count !== 0) begin bad++;
      $display("FAIL reset_counts got rx=%0d tx=%0d want 0/0", rx_count, tx_count); end
    cmp++;
  endtask

  task automatic test_rx_basic();
    u.uart_valid = 1; u.uart_rxd = 8'h41;
    #1;
    if (u.uart_rd !== 1'b1) begin bad++;
      $display("FAIL rx_uart_rd_1 got %b want 1", u.uart_rd); end
    cmp++;
    cyc();
    u.uart_rxd = 8'h42;
    #1;
    if (u.uart_rd !== 1'b1) begin bad++;
      $display("FAIL rx_uart_rd_2 got %b want 1", u.uart_rd); end
    cmp++;
    cyc();
    u.uart_valid = 0;
    #1;
    if (u.uart_rd !== 1'b0) begin bad++;
      $display("FAIL rx_uart_rd_idle got %b want 0", u.uart_rd); end
    cmp++;
    if (rx_count !== 2 || rx_avail !== 1'b1 || rx_data !== 8'h41) begin bad++;
      $display("FAIL rx_two got cnt=%0d av=%b d=%h want 2/1/41",
        rx_count, rx_avail, rx_data); end
    cmp++;
    rd = 1; cyc(); rd = 0;
    if (rx_data !== 8'h42 || rx_count !== 1) begin bad++;
      $display("FAIL rx_second got d=%h cnt=%0d want 42/1", rx_data, rx_count); end
    cmp++;
    rd = 1; cyc(); rd = 0;
    if (rx_avail !== 1'b0) begin bad++;
      $display("FAIL rx_empty got %b want 0", rx_avail); end
    cmp++;
    rd = 1; cyc(); rd = 0;
    if (rx_count !== 0 || rx_avail !== 1'b0 || rx_overrun !== 1'b0) begin bad++;
      $display("FAIL rx_extra_rd got cnt=%0d av=%b ovr=%b want 0/0/0",
        rx_count, rx_avail, rx_overrun); end
    cmp++;
  endtask

  task automatic test_tx_overflow();
    u.uart_busy = 1;
    for (int i = 0; i <= D; i++) begin
      wr = 1; tx_data = 8'(i);
      cyc();
      if (i == D - 1) begin
        if (tx_full !== 1'b1 || tx_overflow !== 1'b0) begin bad++;
          $display("FAIL tx_full16 got full=%b ovf=%b want 1/0", tx_full, tx_overflow); end
        cmp++;
      end
    end
    wr = 0;
    if (tx_overflow !== 1'b1 || tx_count !== cnt_t'(D)) begin bad++;
      $display("FAIL tx_ovf got ovf=%b cnt=%0d want 1/%0d", tx_overflow, tx_count, D); end
    cmp++;
    for (int i = 0; i < D; i++) begin
      u.uart_busy = 0;
      #1;
      if (u.uart_wr !== 1'b1 || u.uart_txd !== 8'(i)) begin bad++;
        $display("FAIL tx_drain_%0d got wr=%b txd=%h want 1/%h",
          i, u.uart_wr, u.uart_txd, 8'(i)); end
      cmp++;
      cyc();
      u.uart_busy = 1;
      #1;
      if (u.uart_wr !== 1'b0) begin bad++;
        $display("FAIL tx_busy_%0d got wr=%b want 0", i, u.uart_wr); end
      cmp++;
      repeat (2) cyc();
    end
    u.uart_busy = 0;
    #1;
    if (tx_count !== 0 || u.uart_wr !== 1'b0) begin bad++;
      $display("FAIL tx_drained got cnt=%0d wr=%b want 0/0", tx_count, u.uart_wr); end
    cmp++;
    clr_err = 1; cyc(); clr_err = 0;
    if (tx_overflow !== 1'b0) begin bad++;
      $display("FAIL tx_clr got %b want 0", tx_overflow); end
    cmp++;
  endtask

  task automatic test_rx_overrun();
    byte unsigned sent[$];
    byte unsigned got;
    for (int i = 0; i < D; i++) begin
      u.uart_valid = 1; u.uart_rxd = 8'($urandom);
      sent.push_back(u.uart_rxd);
      cyc();
    end
    u.uart_valid = 1; u.uart_rxd = 8'hAA;
    cyc();
    u.uart_valid = 0;
    if (rx_overrun !== 1'b1 || rx_count !== cnt_t'(D) || rx_data !== sent[0]) begin
      bad++;
      $display("FAIL rx_ovr got ovr=%b cnt=%0d head=%h want 1/%0d/%h",
        rx_overrun, rx_count, rx_data, D, sent[0]);
    end
    cmp++;
    clr_err = 1; u.uart_valid = 1; u.uart_rxd = 8'hCC;
    cyc();
    u.uart_valid = 0;
    if (rx_overrun !== 1'b1) begin bad++;
      $display("FAIL rx_set_wins got %b want 1", rx_overrun); end
    cmp++;
    cyc();
    clr_err = 0;
    if (rx_overrun !== 1'b0) begin bad++;
      $display("FAIL rx_clr got %b want 0", rx_overrun); end
    cmp++;
    u.uart_valid = 1; u.uart_rxd = 8'hBB; rd = 1;
    cyc();
    u.uart_valid = 0; rd = 0;
    void'(sent.pop_front());
    sent.push_back(8'hBB);
    if (rx_count !== cnt_t'(D) || rx_overrun !== 1'b0) begin bad++;
      $display("FAIL rx_full_pp got cnt=%0d ovr=%b want %0d/0", rx_count, rx_overrun, D); end
    cmp++;
    for (int i = 0; i < D; i++) begin
      got = rx_data;
      if (rx_avail !== 1'b1 || got !== sent[i]) begin bad++;
        $display("FAIL rx_drain_%0d got av=%b d=%h want 1/%h", i, rx_avail, got, sent[i]); end
      cmp++;
      rd = 1; cyc(); rd = 0;
    end
    if (got !== 8'hBB || rx_avail !== 1'b0) begin bad++;
      $display("FAIL rx_last got d=%h av=%b want bb/0", got, rx_avail); end
    cmp++;
  endtask

  task automatic test_tx_latency();
    u.uart_busy = 0; wr = 1; tx_data = 8'h55;
    #1;
    if (u.uart_wr !== 1'b0) begin bad++;
      $display("FAIL tx_no_fallthru got %b want 0", u.uart_wr); end
    cmp++;
    cyc();
    wr = 0;
    if (u.uart_wr !== 1'b1 || u.uart_txd !== 8'h55 || tx_count !== 1) begin bad++;
      $display("FAIL tx_lat got wr=%b txd=%h cnt=%0d want 1/55/1",
        u.uart_wr, u.uart_txd, tx_count); end
    cmp++;
    cyc();
    if (tx_count !== 0 || u.uart_wr !== 1'b0) begin bad++;
      $display("FAIL tx_lat_pop got cnt=%0d wr=%b want 0/0", tx_count, u.uart_wr); end
    cmp++;
  endtask

  task automatic test_wrap_reset();
    byte unsigned src[40];
    int sent = 0;
    int got = 0;
    int budget = 0;
    bit exp_wr;
    foreach (src[i]) src[i] = 8'($urandom);
    while (got < 40 && budget < 1000) begin
      budget++;
      u.uart_valid = (sent < 40) && (rxq.size() < 3);
      u.uart_rxd = (sent < 40) ? src[sent] : 8'h00;
      rd = (rxq.size() >= 3) ||
           (rxq.size() > 1 && $urandom_range(1, 0) == 1) ||
           (sent == 40 && rxq.size() > 0);
      u.uart_busy = ($urandom_range(2, 0) != 0);
      wr = (txq.size() < D - 1) && ($urandom_range(1, 0) == 1);
      tx_data = 8'($urandom);
      #1;
      exp_wr = txq.size() > 0 && !u.uart_busy;
      if (u.uart_wr !== exp_wr) begin bad++;
        $display("FAIL wrap_uart_wr got %b want %b", u.uart_wr, exp_wr); end
      cmp++;
      if (exp_wr && u.uart_txd !== txq[0]) begin bad++;
        $display("FAIL wrap_txd got %h want %h", u.uart_txd, txq[0]); end
      if (exp_wr) cmp++;
      if (rd) begin
        if (rx_avail !== 1'b1 || rx_data !== src[got]) begin bad++;
          $display("FAIL wrap_order_%0d got av=%b d=%h want 1/%h",
            got, rx_avail, rx_data, src[got]); end
        cmp++;
        got++;
      end
      if (u.uart_valid) sent++;
      cyc();
      if (rx_count !== cnt_t'(rxq.size()) || rx_overrun !== 1'b0 ||
          tx_count !== cnt_t'(txq.size()) || tx_overflow !== 1'b0) begin bad++;
        $display("FAIL wrap_state got rc=%0d tc=%0d ovr=%b ovf=%b want %0d/%0d/0/0",
          rx_count, tx_count, rx_overrun, tx_overflow, rxq.size(), txq.size()); end
      cmp++;
    end
    if (got != 40) begin bad++;
      $display("FAIL wrap_budget got %0d bytes want 40", got); end
    cmp++;
    idle_inputs();
    u.uart_busy = 1;
    u.uart_valid = 1; u.uart_rxd = 8'h77;
    wr = 1; tx_data = 8'h88;
    repeat (2) cyc();
    idle_inputs();
    u.uart_busy = 1;
    #3 resetq = 0;
    #1;
    if ({rx_avail, tx_full, rx_overrun, tx_overflow, u.uart_wr} !== 5'b0 ||
        rx_count !== 0 || tx_count !== 0) begin bad++;
      $display("FAIL midreset got av=%b full=%b ovr=%b ovf=%b wr=%b rc=%0d tc=%0d want zeros",
        rx_avail, tx_full, rx_overrun, tx_overflow, u.uart_wr, rx_count, tx_count); end
    cmp++;
    @(posedge clk);
    #1 resetq = 1;
    model_reset();
    u.uart_busy = 0;
  endtask

  task automatic test_random();
    bit exp_wr;
    for (int n = 0; n < 600; n++) begin
      u.uart_valid = ($urandom_range(9, 0) < 6);
      u.uart_rxd = 8'($urandom);
      rd = ($urandom_range(9, 0) < (n < 300 ? 3 : 7));
      wr = ($urandom_range(9, 0) < (n < 300 ? 7 : 3));
      tx_data = 8'($urandom);
      u.uart_busy = ($urandom_range(9, 0) < 6);
      clr_err = ($urandom_range(19, 0) == 0);
      #1;
      exp_wr = txq.size() > 0 && !u.uart_busy;
      if (u.uart_rd !== u.uart_valid || u.uart_wr !== exp_wr) begin bad++;
        $display("FAIL rand_comb got rd=%b wr=%b want %b/%b",
          u.uart_rd, u.uart_wr, u.uart_valid, exp_wr); end
      cmp++;
      if (exp_wr && u.uart_txd !== txq[0]) begin bad++;
        $display("FAIL rand_txd got %h want %h", u.uart_txd, txq[0]); end
      if (exp_wr) cmp++;
      cyc();
      if (rx_count !== cnt_t'(rxq.size()) || tx_count !== cnt_t'(txq.size()) ||
          rx_avail !== (rxq.size() > 0) || tx_full !== (txq.size() == D)) begin bad++;
        $display("FAIL rand_occ got rc=%0d tc=%0d av=%b full=%b want %0d/%0d",
          rx_count, tx_count, rx_avail, tx_full, rxq.size(), txq.size()); end
      cmp++;
      if (rx_overrun !== m_ovr || tx_overflow !== m_ovf) begin bad++;
        $display("FAIL rand_flags got ovr=%b ovf=%b want %b/%b",
          rx_overrun, tx_overflow, m_ovr, m_ovf); end
      cmp++;
      if (rxq.size() > 0 && rx_data !== rxq[0]) begin bad++;
        $display("FAIL rand_rx_head got %h want %h", rx_data, rxq[0]); end
      if (rxq.size() > 0) cmp++;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_rx_basic();
    test_tx_overflow();
    test_rx_overrun();
    test_tx_latency();
    test_wrap_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
